s_memory_arbiter: RTL
=====================

// Module: s_memory_arbiter
// PURPOSE
//  Shares the single-port 256x8 S-memory between the RC4 phase engines (init, shuffle, decrypt).
//  Round-robin ownership arbiter: a requester holds the RAM for a multi-cycle transaction
//  (e.g. read-i/read-j/write-swap) and forwards its address/data/write-enable while granted.
//  Sits between the phase engines and the RAM instance; the top-level sequencer no longer muxes buses.
// PARAMETERS
//  NUM_REQ  3  number of requesters (index 0 = init, 1 = shuffle, 2 = decrypt)
//  ADDR_W   8  RAM address width
//  DATA_W   8  RAM data width
//  RD_LAT   1  cycles from granted read address to valid mem_q (1 to 3)
// PORTS
//  clk          in   1                 system clock, all logic on rising edge
//  reset_n      in   1                 asynchronous, active-low reset
//  req          in   NUM_REQ           per-requester ownership request, held for whole transaction
//  we           in   NUM_REQ           per-requester write enable (qualified by req & grant)
//  addr         in   NUM_REQ*ADDR_W    flattened addresses, requester k at [k*ADDR_W +: ADDR_W]
//  wdata        in   NUM_REQ*DATA_W    flattened write data, same packing
//  grant        out  NUM_REQ           one-hot ownership, registered
//  rdata_valid  out  NUM_REQ           one-hot pulse: rdata holds the read result for that requester
//  rdata        out  DATA_W            registered copy of mem_q for the completing read
//  busy         out  1                 OR of grant
//  mem_address  out  ADDR_W            to RAM
//  mem_data     out  DATA_W            to RAM
//  mem_wren     out  1                 to RAM
//  mem_q        in   DATA_W            from RAM
// BEHAVIOUR
//  Reset (reset_n low, async): grant=0, rdata_valid=0, rdata=0, busy=0; RR pointer=NUM_REQ-1
//   (requester 0 wins first); read pipeline flushed. Reset mid-transaction discards in-flight reads.
//  States: IDLE (grant=0), OWNED(k) (grant[k]=1).
//  IDLE: if any req, next edge -> OWNED(k), k = first requester after RR pointer (wrapping).
//  OWNED(k): stays while req[k]=1. When req[k]=0 at an edge: if other reqs pending,
//   -> OWNED(next after k) at that same edge (no bubble); else -> IDLE. RR pointer <= k on release.
//  Request withdrawn before grant: never granted, no side effect. grant never has >1 bit set.
//  Grant latency: req rising in IDLE -> grant at next edge (1 cycle).
//  Datapath (combinational): access valid when req[k]&grant[k];
//   mem_address=addr[k], mem_data=wdata[k], mem_wren=we[k]&req[k]&grant[k]; when idle
//   mem_address=0, mem_data=0, mem_wren=0.
//  Reads: valid access with we[k]=0 enters an RD_LAT-deep shift register of {valid, k}.
//   At stage RD_LAT, mem_q is sampled: rdata <= mem_q and rdata_valid[k] pulses one cycle, i.e.
//   rdata_valid is seen RD_LAT+1 edges after the address cycle. Reads issued in the last owned
//   cycle still complete to their issuer after ownership moves. One read per cycle sustained.
//  rdata holds its last value between pulses.
// STRUCTURE
//  Package s_memory_pkg: ADDR_W/DATA_W/NUM_REQ constants, REQ_INIT=0, REQ_SHUFFLE=1,
//   REQ_DECRYPT=2 index constants, arb_state_t enum {IDLE, OWNED}.
//  Sub-module rr_priority_picker: combinational, (req, pointer) -> one-hot winner + found flag.
//  Remainder: state/owner regs, RR pointer, output mux, read-tag pipeline.
// TESTING
//  1 Reset: hold reset_n=0 with req=3'b111 -> grant=0, mem_wren=0, rdata_valid=0, busy=0.
//  2 req[0]=1 we[0]=1 addr=0x05 wdata=0xA5 -> grant=3'b001 after 1 edge; same cycle
//    mem_wren=1, mem_address=0x05, mem_data=0xA5.
//  3 req[1] read addr 0x10, RAM returns 0x3C, RD_LAT=1 -> rdata_valid=3'b010, rdata=0x3C
//    exactly 2 edges after the address cycle; pulse is one cycle wide.
//  4 req=3'b111 from reset, each owner drops req after 3 cycles -> grant 001,010,100,001;
//    never two bits set, no idle cycle between owners.
//  5 owner 2 issues read then drops req while req[0]=1 -> grant=3'b001 next edge; the
//    pending read still raises rdata_valid[2], never rdata_valid[0].
//  6 reset_n low during a read in flight -> grant, rdata_valid drop immediately; after release
//    with req=3'b110, requester 1 is granted first.

Source files
------------

// File: rtl/s_memory_arbiter_pkg.sv
// Shared constants and types for the RC4 S-memory arbiter.
package s_memory_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = $clog2(NUM_REQ);

  // Requester indices
  localparam int unsigned REQ_INIT    = 0;
  localparam int unsigned REQ_SHUFFLE = 1;
  localparam int unsigned REQ_DECRYPT = 2;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

  // Index of the set bit in a one-hot (or zero) vector
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/s_memory_arbiter_if.sv
// Engine-side and RAM-side bus of the S-memory arbiter.
interface s_memory_arbiter_if
  import s_memory_pkg::*;
();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rdata_valid;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_wren;
  logic [DATA_W-1:0]         mem_q;

  // Phase engines plus RAM instance
  modport master (
    output req, we, addr, wdata, mem_q,
    input  grant, rdata_valid, rdata, busy, mem_address, mem_data, mem_wren
  );

  // Arbiter
  modport slave (
    input  req, we, addr, wdata, mem_q,
    output grant, rdata_valid, rdata, busy, mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/s_memory_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester strictly after the pointer, wrapping.
module rr_priority_picker
  import s_memory_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               found_o
);

  // Scan ptr+1 .. ptr+NUM_REQ; the pointer itself is checked last
  always_comb begin
    int unsigned idx;
    win_o   = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!found_o && req_i[IDX_W'(idx)]) begin
        win_o[IDX_W'(idx)] = 1'b1;
        found_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s_memory_arbiter.sv
// Round-robin ownership arbiter for the single-port RC4 S-memory.
module s_memory_arbiter
  import s_memory_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  s_memory_arbiter_if.slave bus
);

  arb_state_t                       state_q;
  logic [NUM_REQ-1:0]               grant_q;
  logic [IDX_W-1:0]                 ptr_q;
  logic [NUM_REQ-1:0]               rvalid_q;
  logic [DATA_W-1:0]                rdata_q;
  logic [RD_LAT-1:0]                rd_vld_q;
  logic [RD_LAT-1:0][IDX_W-1:0]     rd_tag_q;

  logic [IDX_W-1:0]   owner_idx;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_win;
  logic               pick_found;
  logic               access_vld;
  logic               rd_issue;

  assign owner_idx = onehot_to_idx(grant_q);

  // While owned, search starts after the current owner so a handover skips it
  assign pick_ptr = (state_q == OWNED) ? owner_idx : ptr_q;

  rr_priority_picker u_picker (
    .req_i   (bus.req),
    .ptr_i   (pick_ptr),
    .win_o   (pick_win),
    .found_o (pick_found)
  );

  // Ownership FSM: grant and RR pointer are registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(REQ_DECRYPT); // requester 0 wins first
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= OWNED;
            grant_q <= pick_win;
          end
        end
        OWNED: begin
          if (!(|(bus.req & grant_q))) begin
            ptr_q <= owner_idx;
            if (pick_found) begin
              grant_q <= pick_win;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Forward the owner's bus to the RAM only while it still requests
  always_comb begin
    access_vld      = |(bus.req & grant_q);
    bus.mem_address = '0;
    bus.mem_data    = '0;
    bus.mem_wren    = 1'b0;
    rd_issue        = 1'b0;
    if (access_vld) begin
      bus.mem_address = bus.addr[int'(owner_idx)*ADDR_W +: ADDR_W];
      bus.mem_data    = bus.wdata[int'(owner_idx)*DATA_W +: DATA_W];
      bus.mem_wren    = bus.we[owner_idx];
      rd_issue        = !bus.we[owner_idx];
    end
  end

  // Read-tag pipeline: the issuer tag travels with the read so it completes
  // to the right requester even after ownership has moved on
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q <= '0;
      rd_tag_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rd_vld_q[0] <= rd_issue;
      rd_tag_q[0] <= owner_idx;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_tag_q[i] <= rd_tag_q[i-1];
      end
      rvalid_q <= '0;
      if (rd_vld_q[RD_LAT-1]) begin
        rvalid_q[rd_tag_q[RD_LAT-1]] <= 1'b1;
        rdata_q                      <= bus.mem_q;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = |grant_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rdata_q;

endmodule
